// File: rtl/bwt_pkg.sv
// Shared types and constants for the BWT sort front-end: byte width, lane indices,
// the pair feeder state encoding and small sizing helpers.
package bwt_pkg;

  localparam int BYTE_W   = 8;
  localparam int LANE_CNT = 2;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WRITE,
    FIN
  } feeder_state_t;

  // A run of one element still needs a 1-bit counter so the wrap compare is well formed.
  function automatic int run_cnt_w(input int run_len);
    return (run_len <= 1) ? 1 : $clog2(run_len);
  endfunction

  function automatic logic [LANE_CNT-1:0] lane_strobe(input logic sel);
    return (sel == LANE1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lane_sel_ctr.sv
// Run position counter and lane selector: counts elements within a run and flips
// the target lane each time a run of RUN_LEN elements completes.
module lane_sel_ctr
  import bwt_pkg::*;
#(
  parameter int RUN_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic clr,
  output logic sel,
  output logic wrap
);

  localparam int CW = run_cnt_w(RUN_LEN);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_LEN - 1);

  logic [CW-1:0] run_cnt;

  assign wrap = step && (run_cnt == RUN_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      run_cnt <= '0;
      sel     <= LANE0;
    end else if (step) begin
      if (wrap) begin
        run_cnt <= '0;
        sel     <= ~sel;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pair_feeder.sv
// Pops bytes from the source FIFO and writes them to two lane FIFOs in alternating
// runs of RUN_LEN, pulsing pair_done whenever a lane-0/lane-1 run pair is complete.
module pair_feeder
  import bwt_pkg::*;
#(
  parameter int RUN_LEN = 1,
  parameter int LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [BYTE_W-1:0]   src_data,
  input  logic                src_empty,
  output logic                src_rd,
  input  logic [LANE_CNT-1:0] lane_full,
  output logic [BYTE_W-1:0]   lane_data,
  output logic [LANE_CNT-1:0] lane_wr,
  output logic                pair_done,
  output logic                busy,
  output logic                done
);

  feeder_state_t state, state_nxt;

  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] elem_cnt;
  logic             sel;
  logic             wrap;
  logic             step;
  logic             clr;
  logic             last_elem;

  assign last_elem = (elem_cnt == (len - LEN_W'(1)));

  lane_sel_ctr #(
    .RUN_LEN (RUN_LEN)
  ) u_lane_sel_ctr (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .clr  (clr),
    .sel  (sel),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One byte costs FETCH, CAPTURE, WRITE; the full flag is checked only in FETCH,
  // by which time the previous write has already landed in the lane FIFO.
  always_comb begin
    state_nxt = state;
    src_rd    = 1'b0;
    step      = 1'b0;
    clr       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (cfg_len == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        busy   = 1'b1;
        src_rd = !src_empty && !lane_full[sel];
        if (src_rd) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        step      = 1'b1;
        state_nxt = last_elem ? FIN : FETCH;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A pair closes when lane 1 finishes its run, or early when the transfer ends
  // with a partially filled pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      elem_cnt  <= '0;
      lane_data <= '0;
      lane_wr   <= '0;
      pair_done <= 1'b0;
    end else begin
      lane_wr   <= '0;
      pair_done <= 1'b0;
      if (state == IDLE && start) begin
        len      <= cfg_len;
        elem_cnt <= '0;
      end
      if (state == CAPTURE) begin
        lane_data <= src_data;
        lane_wr   <= lane_strobe(sel);
      end
      if (step) begin
        elem_cnt  <= elem_cnt + LEN_W'(1);
        pair_done <= (wrap && (sel == LANE1)) || last_elem;
      end
    end
  end

endmodule
